// File: rtl/reaction_timer_counter.sv
// rtl/reaction_timer_counter.sv - ms timer for the reaction-time FSM: random-delay countdown and reaction count-up
// Also supplies a free-running LED index captured at each delay load.
module reaction_timer_counter #(
  parameter int CLKS_PER_MS  = 50000,
  parameter int MAX_MS       = 2047,
  parameter int LED_NUM      = 17,
  parameter int DELAY_MIN_MS = 1000,
  parameter int DELAY_MASK   = 1023,
  localparam int W  = $clog2(MAX_MS),
  localparam int L  = $clog2(LED_NUM),
  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         reset,
  input  logic         up,
  input  logic         enable,
  output logic [W-1:0] timer_value,
  output logic [L-1:0] random_value,
  output logic         ms_tick,
  output logic         saturated
);

  logic [15:0]   lfsr_q, lfsr_d;
  logic [L-1:0]  led_idx_q, led_idx_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [W-1:0]  timer_q, timer_d;
  logic [L-1:0]  random_q, random_d;
  logic          tick_q, tick_d;
  logic          sat_q, sat_d;
  logic          load_pending_q, load_pending_d;

  logic [W:0]    delay_w;
  logic [W:0]    inc_w;
  logic          feedback;
  logic          presc_last;

  assign feedback   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign delay_w    = (W+1)'(DELAY_MIN_MS) + (W+1)'(lfsr_q & 16'(DELAY_MASK));
  assign inc_w      = {1'b0, timer_q} + (W+1)'(1);
  assign presc_last = (prescaler_q == PW'(CLKS_PER_MS - 1));

  always_comb begin
    lfsr_d         = {lfsr_q[14:0], feedback};
    led_idx_d      = (led_idx_q == L'(LED_NUM - 1)) ? '0 : led_idx_q + L'(1);
    timer_d        = timer_q;
    prescaler_d    = prescaler_q;
    random_d       = random_q;
    tick_d         = 1'b0;
    sat_d          = sat_q;
    load_pending_d = load_pending_q | ~up;

    // A load only fires once per delay phase; further reset cycles with up=1 clear instead.
    if (reset && up && load_pending_q) begin
      timer_d        = delay_w[W-1:0];
      random_d       = led_idx_q;
      prescaler_d    = '0;
      load_pending_d = 1'b0;
      sat_d          = 1'b0;
    end else if (reset) begin
      timer_d     = '0;
      prescaler_d = '0;
      sat_d       = 1'b0;
    end else if (enable) begin
      if (presc_last) begin
        prescaler_d = '0;
        tick_d      = 1'b1;
        if (up) begin
          if (timer_q != '0) timer_d = timer_q - W'(1);
          sat_d = 1'b0;
        end else if (inc_w >= (W+1)'(MAX_MS)) begin
          timer_d = W'(MAX_MS);
          sat_d   = 1'b1;
        end else begin
          timer_d = inc_w[W-1:0];
        end
      end else begin
        prescaler_d = prescaler_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q         <= 16'hACE1;
      led_idx_q      <= '0;
      prescaler_q    <= '0;
      timer_q        <= '0;
      random_q       <= '0;
      tick_q         <= 1'b0;
      sat_q          <= 1'b0;
      load_pending_q <= 1'b1;
    end else begin
      lfsr_q         <= lfsr_d;
      led_idx_q      <= led_idx_d;
      prescaler_q    <= prescaler_d;
      timer_q        <= timer_d;
      random_q       <= random_d;
      tick_q         <= tick_d;
      sat_q          <= sat_d;
      load_pending_q <= load_pending_d;
    end
  end

  assign timer_value  = timer_q;
  assign random_value = random_q;
  assign ms_tick      = tick_q;
  assign saturated    = sat_q;

endmodule

// File: tb/tb_reaction_timer_counter.sv
// tb/tb_reaction_timer_counter.sv - self-checking bench for reaction_timer_counter
// dut_a uses the full-range delay, dut_b a small MAX_MS for saturation.
module tb_reaction_timer_counter;

  logic clk = 1'b0;
  logic rst, reset, up, enable;

  logic [10:0] tv_a;
  logic [4:0]  rv_a;
  logic        tick_a, sat_a;
  logic [3:0]  tv_b;
  logic [4:0]  rv_b;
  logic        tick_b, sat_b;

  reaction_timer_counter #(.CLKS_PER_MS(4)) dut_a (
    .clk(clk), .rst(rst), .reset(reset), .up(up), .enable(enable),
    .timer_value(tv_a), .random_value(rv_a), .ms_tick(tick_a), .saturated(sat_a)
  );

  reaction_timer_counter #(.CLKS_PER_MS(4), .MAX_MS(10), .DELAY_MIN_MS(2), .DELAY_MASK(7)) dut_b (
    .clk(clk), .rst(rst), .reset(reset), .up(up), .enable(enable),
    .timer_value(tv_b), .random_value(rv_b), .ms_tick(tick_b), .saturated(sat_b)
  );

  always #5 clk = ~clk;

  // Reference for the free-running random sources.
  logic [15:0] m_lfsr;
  int          m_led;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= 16'hACE1;
      m_led  <= 0;
    end else begin
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_led  <= (m_led == 16) ? 0 : m_led + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // -1 in any field means "not checked on this cycle".
  typedef struct {
    string name;
    int tv_a, tv_b, tick, sat_a, sat_b, rv;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input string n, input int ta, input int tb, input int tk,
                              input int sa, input int sbv, input int r);
    exp_t x;
    x.name = n; x.tv_a = ta; x.tv_b = tb; x.tick = tk; x.sat_a = sa; x.sat_b = sbv; x.rv = r;
    return x;
  endfunction

  task automatic step(input logic r, input logic u, input logic e, input exp_t x);
    exp_t y;
    reset = r; up = u; enable = e;
    sb.push_back(x);
    @(negedge clk);
    y = sb.pop_front();
    if (y.tv_a  >= 0) check({y.name, " timer_a"},  32'(tv_a),   y.tv_a);
    if (y.tv_b  >= 0) check({y.name, " timer_b"},  32'(tv_b),   y.tv_b);
    if (y.tick  >= 0) check({y.name, " ms_tick"},  32'(tick_a), y.tick);
    if (y.tick  >= 0) check({y.name, " ms_tick_b"},32'(tick_b), y.tick);
    if (y.sat_a >= 0) check({y.name, " sat_a"},    32'(sat_a),  y.sat_a);
    if (y.sat_b >= 0) check({y.name, " sat_b"},    32'(sat_b),  y.sat_b);
    if (y.rv    >= 0) check({y.name, " random_a"}, 32'(rv_a),   y.rv);
    if (y.rv    >= 0) check({y.name, " random_b"}, 32'(rv_b),   y.rv);
  endtask

  typedef struct {
    logic reset, up, enable;
    int tv_a, tv_b, tick, sat_b;
  } vec_t;

  vec_t tbl[50];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int ea, eb, led;

    for (int k = 1; k <= 46; k++)
      tbl[k-1] = '{1'b0, 1'b0, 1'b1, k/4, (k/4 > 10) ? 10 : k/4, (k % 4 == 0) ? 1 : 0, (k/4 >= 10) ? 1 : 0};
    for (int k = 46; k < 50; k++)
      tbl[k] = '{1'b0, 1'b0, 1'b0, 11, 10, 0, 1};

    rst = 1'b1; reset = 1'b0; up = 1'b0; enable = 1'b0;
    repeat (2) @(negedge clk);
    check("rst timer_a",  32'(tv_a),   0);
    check("rst random_a", 32'(rv_a),   0);
    check("rst tick_a",   32'(tick_a), 0);
    check("rst sat_a",    32'(sat_a),  0);
    check("rst timer_b",  32'(tv_b),   0);
    check("rst sat_b",    32'(sat_b),  0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, mk("idle", 0, 0, 0, 0, 0, 0));

    ea  = 1000 + int'(m_lfsr & 16'd1023);
    eb  = 2 + int'(m_lfsr & 16'd7);
    led = m_led;
    step(1'b1, 1'b1, 1'b0, mk("load", ea, eb, 0, 0, 0, led));
    check("load range", 32'((tv_a >= 11'd1000) && (tv_a <= 11'd2023)), 1);
    check("led range",  32'(rv_a < 5'd17), 1);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, mk("no_reload", 0, 0, 0, 0, 0, led));

    step(1'b1, 1'b0, 1'b0, mk("arm", 0, 0, 0, 0, 0, led));
    ea  = 1000 + int'(m_lfsr & 16'd1023);
    eb  = 2 + int'(m_lfsr & 16'd7);
    led = m_led;
    step(1'b1, 1'b1, 1'b0, mk("reload", ea, eb, 0, 0, 0, led));

    for (int k = 1; k <= 4*ea + 8; k++) begin
      int ta, tb;
      ta = (k >= 4*ea - 1) ? ((ea - k/4 > 0) ? ea - k/4 : 0) : ((k == 4) ? ea - 1 : -1);
      tb = (k <= 4*eb + 8) ? ((eb - k/4 > 0) ? eb - k/4 : 0) : -1;
      step(1'b0, 1'b1, 1'b1, mk("countdown", ta, tb, (k % 4 == 0) ? 1 : 0, 0, 0, led));
    end

    step(1'b1, 1'b0, 1'b0, mk("clear", 0, 0, 0, 0, 0, led));
    foreach (tbl[i])
      step(tbl[i].reset, tbl[i].up, tbl[i].enable,
           mk("countup", tbl[i].tv_a, tbl[i].tv_b, tbl[i].tick, 0, tbl[i].sat_b, led));

    // Prescaler sits at 2 here; switching direction must not restart it.
    step(1'b0, 1'b1, 1'b1, mk("toggle1", 11, 10, 0, 0, -1, led));
    step(1'b0, 1'b1, 1'b1, mk("toggle2", 10, 9, 1, 0, -1, led));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, mk("toggle_wait", 10, 9, 0, 0, -1, led));
    step(1'b0, 1'b0, 1'b1, mk("toggle_up", 11, 10, 1, 0, -1, led));

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, mk("pre_tick", 11, 10, 0, 0, -1, led));
    step(1'b1, 1'b0, 1'b1, mk("reset_vs_tick", 0, 0, 0, 0, 0, led));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, mk("post_reset", 0, 0, 0, 0, 0, led));
    step(1'b0, 1'b0, 1'b1, mk("post_reset_tick", 1, 1, 1, 0, 0, led));

    for (int k = 1; k <= 16; k++)
      step(1'b0, 1'b0, 1'b1, mk("to_five", 1 + k/4, 1 + k/4, (k % 4 == 0) ? 1 : 0, 0, 0, led));

    #2 rst = 1'b1;
    #1;
    check("async timer_a",  32'(tv_a),   0);
    check("async timer_b",  32'(tv_b),   0);
    check("async random_a", 32'(rv_a),   0);
    check("async tick_a",   32'(tick_a), 0);
    check("async sat_a",    32'(sat_a),  0);
    @(negedge clk);
    rst = 1'b0;

    ea  = 1000 + int'(m_lfsr & 16'd1023);
    eb  = 2 + int'(m_lfsr & 16'd7);
    led = m_led;
    step(1'b1, 1'b1, 1'b0, mk("rst_reload", ea, eb, 0, 0, 0, led));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
